// File: rtl/gray_code_counter_if.sv
// Control and status bundle for gray_code_counter. The master drives the controls.
// The slave (the counter) returns the registered Gray code, the binary count and the status flags.
interface gray_code_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] G;
  logic [WIDTH-1:0] bin_q;
  logic             wrap;
  logic             at_end;

  // There is no valid/ready pair. Every control is sampled at each rising clk edge.
  // The registered outputs are valid from that edge until the next one.
  modport master (
    output en, up_dn, load, load_bin,
    input  G, bin_q, wrap, at_end
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output G, bin_q, wrap, at_end
  );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down counter that keeps a binary count and a registered Gray copy derived from the same next value.
// Outputs: a wrap pulse, and an end-of-range flag for the current count direction.
module gray_code_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  gray_code_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_BIN = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;
  logic             at_end_r;

  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  // Priority is load over en. Reset is handled in the register itself.
  always_comb begin
    next_bin  = bin_r;
    next_wrap = 1'b0;
    if (bus.load) begin
      next_bin = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (bin_r == MAX_BIN) begin
          if (SATURATE == 0) begin
            next_bin  = '0;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = bin_r + ONE;
        end
      end else begin
        if (bin_r == '0) begin
          if (SATURATE == 0) begin
            next_bin  = MAX_BIN;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = bin_r - ONE;
        end
      end
    end
  end

  // G and at_end are both derived from the value being registered, so they never lag bin_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r    <= RST_BIN;
      gray_r   <= RST_BIN ^ (RST_BIN >> 1);
      wrap_r   <= 1'b0;
      at_end_r <= bus.up_dn ? (RST_BIN == MAX_BIN) : (RST_BIN == '0);
    end else begin
      bin_r    <= next_bin;
      gray_r   <= next_bin ^ (next_bin >> 1);
      wrap_r   <= next_wrap;
      at_end_r <= bus.up_dn ? (next_bin == MAX_BIN) : (next_bin == '0);
    end
  end

  assign bus.G      = gray_r;
  assign bus.bin_q  = bin_r;
  assign bus.wrap   = wrap_r;
  assign bus.at_end = at_end_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// Drives a wrapping counter (dut0) and a saturating counter (dut1) from the same stimulus.
// Both are checked against an arithmetic count model and a table of the 4-bit Gray sequence.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, load;
  logic [3:0] load_bin;

  int n_checks = 0;
  int n_errors = 0;

  // The reflected 4-bit Gray sequence, indexed by binary value.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  int   m_cnt  [2];
  logic m_wrap [2];
  logic m_end  [2];
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  gray_code_counter_if #(.WIDTH(4)) ifc0 ();
  gray_code_counter_if #(.WIDTH(4)) ifc1 ();

  assign ifc0.en = en;  assign ifc0.up_dn = up_dn;  assign ifc0.load = load;  assign ifc0.load_bin = load_bin;
  assign ifc1.en = en;  assign ifc1.up_dn = up_dn;  assign ifc1.load = load;  assign ifc1.load_bin = load_bin;

  gray_code_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  gray_code_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  logic [9:0] obs [2];
  assign obs[0] = {ifc0.G, ifc0.bin_q, ifc0.wrap, ifc0.at_end};
  assign obs[1] = {ifc1.G, ifc1.bin_q, ifc1.wrap, ifc1.at_end};

  function automatic logic [9:0] exp_of(int d);
    logic [3:0] b;
    b = 4'(m_cnt[d]);
    return {gray_tab[m_cnt[d]], b, m_wrap[d], m_end[d]};
  endfunction

  // Reference behaviour from the counting rules: plain integer arithmetic on the range 0..15.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int c;
      bit w;
      c = m_cnt[d];
      w = 1'b0;
      if (rst)       c = 0;
      else if (load) c = int'(load_bin);
      else if (en) begin
        if (up_dn) begin
          if (c == 15) begin if (d == 0) begin c = 0; w = 1'b1; end end
          else c = c + 1;
        end else begin
          if (c == 0) begin if (d == 0) begin c = 15; w = 1'b1; end end
          else c = c - 1;
        end
      end
      m_cnt[d]  = c;
      m_wrap[d] = w;
      m_end[d]  = up_dn ? (c == 15) : (c == 0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_bin = 4'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_of(d) || obs[d][9:2] !== 8'h00) begin
          n_errors++;
          $display("FAIL reset dut%0d: got {G,bin,wrap,end}=%b expected %b", d, obs[d], exp_of(d));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] prev_g;
    int         gb;
    en = 1'b1; up_dn = 1'b1;
    prev_g = ifc0.G;
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_of(d)) begin
          n_errors++;
          $display("FAIL count_up step%0d dut%0d: got %b expected %b", i, d, obs[d], exp_of(d));
        end
      end
      n_checks++;
      if ($countones(ifc0.G ^ prev_g) != 1) begin
        n_errors++;
        $display("FAIL one_bit_step step%0d: got G %b after %b, required a single-bit change", i, ifc0.G, prev_g);
      end
      gb = -1;
      for (int k = 0; k < 16; k++) if (gray_tab[k] === ifc0.G) gb = k;
      n_checks++;
      if (gb != int'(ifc0.bin_q)) begin
        n_errors++;
        $display("FAIL g_to_b step%0d: decoded %0d from G, bin_q=%0d", i, gb, ifc0.bin_q);
      end
      prev_g = ifc0.G;
    end
  endtask

  task automatic test_count_down();
    en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_of(d)) begin
          n_errors++;
          $display("FAIL count_down step%0d dut%0d: got %b expected %b", i, d, obs[d], exp_of(d));
        end
      end
    end
  endtask

  task automatic test_load();
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_bin = 4'd9;
    tick();
    n_checks++;
    if (ifc0.G !== 4'b1101 || ifc0.bin_q !== 4'd9 || ifc0.wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL load_value: got G=%b bin=%0d wrap=%b, required G=1101 bin=9 wrap=0", ifc0.G, ifc0.bin_q, ifc0.wrap);
    end
    load = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== exp_of(d)) begin
        n_errors++;
        $display("FAIL load_then_count dut%0d: got %b expected %b", d, obs[d], exp_of(d));
      end
    end
  endtask

  task automatic test_hold();
    load = 1'b1; load_bin = 4'd6; en = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_dn = 1'($urandom_range(0, 1));
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_of(d) || obs[d][9:6] !== 4'b0101) begin
          n_errors++;
          $display("FAIL hold cyc%0d dut%0d: got %b expected %b", i, d, obs[d], exp_of(d));
        end
      end
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_bin = 4'd15; en = 1'b0; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ifc1.G !== 4'b1000 || ifc1.wrap !== 1'b0 || ifc1.at_end !== 1'b1) begin
        n_errors++;
        $display("FAIL saturate cyc%0d: got G=%b wrap=%b end=%b, required 1000 0 1", i, ifc1.G, ifc1.wrap, ifc1.at_end);
      end
      n_checks++;
      if (obs[0] !== exp_of(0)) begin
        n_errors++;
        $display("FAIL saturate_wrapper cyc%0d: got %b expected %b", i, obs[0], exp_of(0));
      end
    end
    rst = 1'b1; load = 1'b1; load_bin = 4'($urandom_range(1, 15));
    tick();
    rst = 1'b0; load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== exp_of(d) || obs[d][9:2] !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_over_load dut%0d: got %b expected %b", d, obs[d], exp_of(d));
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] e;
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      load_bin = 4'($urandom);
      model_step();
      exp_q.push_back(exp_of(0));
      exp_q.push_back(exp_of(1));
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs[d] !== e) begin
          n_errors++;
          $display("FAIL random cyc%0d dut%0d: got %b expected %b", i, d, obs[d], e);
        end
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    m_cnt  = '{0, 0};
    m_wrap = '{1'b0, 1'b0};
    m_end  = '{1'b0, 1'b0};
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
